// File: rtl/ce_pkg.sv
// ce_pkg: definitions shared by the CE datapath blocks (ce_window_gen, CE_net).
//   ce_kernel_legal(k) : 1 when k is a supported window size (1, 3, 5, 7)
//   ce_k2(k)           : number of window elements per channel (k*k)
package ce_pkg;

    localparam int CE_KERNEL_MAX = 7;

    function automatic bit ce_kernel_legal(input int kernel);
        return (kernel == 1) || (kernel == 3) || (kernel == 5) || (kernel == 7);
    endfunction

    function automatic int ce_k2(input int kernel);
        return kernel * kernel;
    endfunction

endpackage

// File: rtl/ce_line_buf.sv
// ce_line_buf: DEPTH-entry delay line that advances only when en is high.
//   clk, rst : clock, asynchronous active-high reset (clears the pointer only)
//   en       : advance; din is written and the oldest entry retires
//   din      : WIDTH-bit sample in
//   dout     : sample written DEPTH enables ago (the entry about to be overwritten)
module ce_line_buf #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (int'(ptr_q) == DEPTH - 1) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is deliberately not reset: stale entries are always overwritten
    // before the window logic can expose them.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[ptr_q] <= din;
        end
    end

    assign dout = mem_q[ptr_q];

endmodule

// File: rtl/ce_window_gen.sv
// ce_window_gen: sliding KERNEL x KERNEL window generator over a raster pixel
// stream, emitting only fully-inside (unpadded) windows.
//   clk, rst   : clock, asynchronous active-high reset
//   sof        : start of frame; the pixel accepted with it (or the next one) is (0,0)
//   din        : one pixel, channel c at din[c*N +: N]
//   din_valid  : din accepted this cycle (no back-pressure)
//   data2conv  : window, element (c,r,x) at bit offset (c*K2 + r*KERNEL + x)*N
//   en_out     : data2conv valid, one cycle after the bottom-right pixel is accepted
//   eof_out    : with en_out, marks the last window of the frame
module ce_window_gen
    import ce_pkg::*;
#(
    parameter int CL_IN  = 1,
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sof,
    input  logic [CL_IN*N-1:0]               din,
    input  logic                             din_valid,
    output logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv,
    output logic                             en_out,
    output logic                             eof_out
);

    localparam int K2 = ce_k2(KERNEL);
    localparam int PW = CL_IN * N;
    localparam int WW = CL_IN * K2 * N;
    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);

    if (!ce_kernel_legal(KERNEL)) begin : g_bad_kernel
        $error("ce_window_gen: KERNEL must be 1, 3, 5 or 7");
    end
    if (IMG_W < KERNEL || IMG_H < KERNEL) begin : g_bad_frame
        $error("ce_window_gen: frame smaller than KERNEL");
    end

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          sof_pend_q, sof_pend_d;
    logic          restart;
    logic [WW-1:0] win_q, win_d;
    logic [WW-1:0] data_q, data_d;
    logic          en_q, en_d;
    logic          eof_q, eof_d;

    // tap[0] is the incoming pixel; tap[j] is the same column j lines earlier.
    logic [PW-1:0] tap [KERNEL];

    assign tap[0] = din;

    for (genvar j = 0; j < KERNEL - 1; j++) begin : g_lb
        ce_line_buf #(
            .DEPTH (IMG_W),
            .WIDTH (PW)
        ) u_line_buf (
            .clk  (clk),
            .rst  (rst),
            .en   (din_valid),
            .din  (tap[j]),
            .dout (tap[j+1])
        );
    end

    // Position of the pixel being accepted; a pending or present sof overrides it.
    always_comb begin
        restart    = din_valid && (sof || sof_pend_q);
        cur_col    = restart ? '0 : col_q;
        cur_row    = restart ? '0 : row_q;
        col_d      = col_q;
        row_d      = row_q;
        sof_pend_d = sof_pend_q;
        if (din_valid) begin
            sof_pend_d = 1'b0;
            if (int'(cur_col) == IMG_W - 1) begin
                col_d = '0;
                row_d = (int'(cur_row) == IMG_H - 1) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end else if (sof) begin
            sof_pend_d = 1'b1;
        end
    end

    // Shift each window row left and load the new rightmost column: row r comes
    // from the tap that is KERNEL-1-r lines old, so the bottom row is din itself.
    always_comb begin
        win_d = win_q;
        if (din_valid) begin
            for (int c = 0; c < CL_IN; c++) begin
                for (int r = 0; r < KERNEL; r++) begin
                    for (int x = 0; x < KERNEL; x++) begin
                        if (x < KERNEL - 1) begin
                            win_d[(c*K2 + r*KERNEL + x)*N +: N] = win_q[(c*K2 + r*KERNEL + x + 1)*N +: N];
                        end else begin
                            win_d[(c*K2 + r*KERNEL + x)*N +: N] = tap[KERNEL-1-r][c*N +: N];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        en_d   = din_valid && (int'(cur_row) >= KERNEL - 1) && (int'(cur_col) >= KERNEL - 1);
        eof_d  = en_d && (int'(cur_row) == IMG_H - 1) && (int'(cur_col) == IMG_W - 1);
        data_d = en_d ? win_d : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            sof_pend_q <= 1'b0;
            en_q       <= 1'b0;
            eof_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            sof_pend_q <= sof_pend_d;
            en_q       <= en_d;
            eof_q      <= eof_d;
            data_q     <= data_d;
        end
    end

    // The window itself needs no reset: every column is reloaded before a
    // qualifying pixel can publish it.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign data2conv = data_q;
    assign en_out    = en_q;
    assign eof_out   = eof_q;

endmodule

// File: tb/tb_ce_window_gen.sv
// tb_ce_window_gen: drives one shared pixel stream into a KERNEL=3 (5x4 frame)
// instance and a KERNEL=1 (2x2 frame) instance, and compares both against
// frame-image reference models every cycle.
module tb_ce_window_gen;

    localparam int K  = 3;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int BW = 2;
    localparam int BH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sof = 1'b0;
    logic [3:0]  din = '0;
    logic        din_valid = 1'b0;

    logic [35:0] a_data;
    logic        a_en, a_eof;
    logic [3:0]  b_data;
    logic        b_en, b_eof;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ce_window_gen #(.CL_IN(1), .KERNEL(K), .N(4), .IMG_W(W), .IMG_H(H)) u_dut_a (
        .clk(clk), .rst(rst), .sof(sof), .din(din), .din_valid(din_valid),
        .data2conv(a_data), .en_out(a_en), .eof_out(a_eof)
    );

    ce_window_gen #(.CL_IN(1), .KERNEL(1), .N(4), .IMG_W(BW), .IMG_H(BH)) u_dut_b (
        .clk(clk), .rst(rst), .sof(sof), .din(din), .din_valid(din_valid),
        .data2conv(b_data), .en_out(b_en), .eof_out(b_eof)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference models ----------------
    // A: remembers every pixel of the current frame by (row, col) and builds
    // the window directly from the image.
    logic [3:0]  img [H][W];
    int          ar = 0, ac = 0, acc_since = 0, a_win_acc = 0;
    bit          apend = 0;
    logic        m_a_en = 0, m_a_eof = 0;
    logic [35:0] m_a_data = '0;
    // B: KERNEL=1, every accepted pixel is a window.
    int          br = 0, bc = 0;
    bit          bpend = 0;
    logic        m_b_en = 0, m_b_eof = 0;
    logic [3:0]  m_b_data = '0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            ar = 0; ac = 0; apend = 0; acc_since = 0;
            m_a_en = 0; m_a_eof = 0; m_a_data = '0;
            br = 0; bc = 0; bpend = 0;
            m_b_en = 0; m_b_eof = 0; m_b_data = '0;
        end else begin
            m_a_en = 0; m_a_eof = 0; m_b_en = 0; m_b_eof = 0;
            if (din_valid) begin
                if (sof || apend) begin ar = 0; ac = 0; acc_since = 0; end
                apend = 0;
                acc_since++;
                img[ar][ac] = din;
                if (ar >= K - 1 && ac >= K - 1) begin
                    m_a_en  = 1;
                    m_a_eof = (ar == H - 1 && ac == W - 1);
                    a_win_acc = acc_since;
                    for (int r = 0; r < K; r++)
                        for (int x = 0; x < K; x++)
                            m_a_data[(r*K + x)*4 +: 4] = img[ar-K+1+r][ac-K+1+x];
                end
                ac++;
                if (ac == W) begin ac = 0; ar = (ar == H - 1) ? 0 : ar + 1; end

                if (sof || bpend) begin br = 0; bc = 0; end
                bpend = 0;
                m_b_en = 1;
                m_b_eof = (br == BH - 1 && bc == BW - 1);
                m_b_data = din;
                bc++;
                if (bc == BW) begin bc = 0; br = (br == BH - 1) ? 0 : br + 1; end
            end else if (sof) begin
                apend = 1;
                bpend = 1;
            end
        end
    end

    // ---------------- compare + window capture ----------------
    logic [35:0] aq[$];
    bit          aeq[$];
    int          aacc[$];
    logic [3:0]  bq[$];
    bit          beq[$];

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("a_en",   a_en,   m_a_en);
            chk("a_eof",  a_eof,  m_a_eof);
            chk("a_data", a_data, m_a_data);
            chk("b_en",   b_en,   m_b_en);
            chk("b_eof",  b_eof,  m_b_eof);
            chk("b_data", b_data, m_b_data);
            if (a_en) begin aq.push_back(a_data); aeq.push_back(a_eof); aacc.push_back(a_win_acc); end
            if (b_en) begin bq.push_back(b_data); beq.push_back(b_eof); end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] v, input bit s, input int gap_max, input bit gap_sof);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin
            @(negedge clk);
            din_valid = 1'b0;
            din = 4'($urandom);
            sof = gap_sof && ($urandom_range(15, 0) == 0);
        end
        @(negedge clk);
        din = v; sof = s; din_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0; sof = 1'b0; din = 4'($urandom);
        end
    endtask

    task automatic send_frame(input int first, input int count, input bit sof_first, input int gap_max);
        for (int i = 0; i < count; i++)
            drive(4'((first + i) % 16), sof_first && (i == 0), gap_max, 1'b0);
    endtask

    task automatic clear_q();
        aq.delete(); aeq.delete(); aacc.delete(); bq.delete(); beq.delete();
    endtask

    task automatic pulse_rst();
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_async_a_en",   a_en,   1'b0);
        chk("rst_async_a_data", a_data, 36'h0);
        @(posedge clk); #2 rst = 1'b0;
    endtask

    localparam logic [35:0] WIN_FIRST = 36'hCBA765210;
    localparam logic [35:0] WIN_LAST  = 36'h321EDC987;

    logic [35:0] ref_win[$];

    initial begin
        int eof_sum;
        repeat (3) @(negedge clk);
        chk("reset_a_en",   a_en,   1'b0);
        chk("reset_a_eof",  a_eof,  1'b0);
        chk("reset_a_data", a_data, 36'h0);
        chk("reset_b_data", b_data, 4'h0);
        @(posedge clk); #2 rst = 1'b0;
        idle(2);

        // KERNEL=1, 2x2 frame: pixels 0..3
        clear_q();
        send_frame(0, 4, 1'b1, 0);
        idle(3);
        chk("k1_count", bq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("k1_value", bq[i], 4'(i));
            chk("k1_eof", beq[i], i == 3);
        end

        // Continuous full frame
        clear_q();
        send_frame(0, 20, 1'b1, 0);
        idle(3);
        chk("full_count", aq.size(), 6);
        chk("full_first", aq[0], WIN_FIRST);
        chk("full_first_acc", aacc[0], 13);
        chk("full_last", aq[5], WIN_LAST);
        chk("full_last_eof", aeq[5], 1'b1);
        eof_sum = 0;
        for (int i = 0; i < 5; i++) eof_sum += int'(aeq[i]);
        chk("full_other_eof", eof_sum, 0);
        ref_win = aq;

        // Same frame with random valid gaps
        clear_q();
        send_frame(0, 20, 1'b1, 4);
        idle(3);
        chk("gap_count", aq.size(), 6);
        for (int i = 0; i < 6; i++) chk("gap_window", aq[i], ref_win[i]);

        // Reset after pixel (2,3), then resend without sof
        send_frame(0, 14, 1'b1, 0);
        idle(2);
        pulse_rst();
        clear_q();
        send_frame(0, 20, 1'b0, 0);
        idle(3);
        chk("rst_count", aq.size(), 6);
        chk("rst_first", aq[0], WIN_FIRST);
        chk("rst_first_acc", aacc[0], 13);
        chk("rst_last", aq[5], WIN_LAST);

        // sof with din_valid where pixel (1,1) would be
        send_frame(0, 6, 1'b1, 0);
        clear_q();
        send_frame(0, 20, 1'b1, 0);
        idle(3);
        chk("sof_count", aq.size(), 6);
        chk("sof_first", aq[0], WIN_FIRST);
        chk("sof_first_acc", aacc[0], 13);

        // Randomized frames: random pixels, gaps, stray sof with and without valid
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 20; i++)
                drive(4'($urandom), (i == 0) || ($urandom_range(40, 0) == 0), 3, 1'b1);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
